// File: rtl/controledivisao8x8.sv
// controledivisao8x8: sequential 8-bit restoring divider, one stage per clock, MSB first.
module controledivisao8x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       busy,
  output logic       done,
  output logic       erro_div0
);
  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] dividendo_q, dividendo_d;
  logic [7:0] divisor_q, divisor_d;
  logic [7:0] resto_q, resto_d;
  logic [7:0] quociente_q, quociente_d;
  logic [2:0] contador_q, contador_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic       erro_q, erro_d;
  logic       div0_q, div0_d;
  logic [7:0] parcial;
  logic [8:0] diff;
  logic       borrow;
  logic [7:0] resto_nx;
  logic [7:0] quociente_nx;
  always_comb begin
    parcial      = {resto_q[6:0], dividendo_q[contador_q]};
    diff         = {1'b0, parcial} - {1'b0, divisor_q};
    borrow       = diff[8];
    resto_nx     = borrow ? parcial : diff[7:0];
    quociente_nx = {quociente_q[6:0], ~borrow};
    state_d      = state_q;
    dividendo_d  = dividendo_q;
    divisor_d    = divisor_q;
    resto_d      = resto_q;
    quociente_d  = quociente_q;
    contador_d   = contador_q;
    q_d          = q_q;
    r_d          = r_q;
    erro_d       = erro_q;
    div0_d       = div0_q;
    case (state_q)
      OCIOSO: if (start) begin
        dividendo_d = A;
        divisor_d   = B;
        resto_d     = 8'd0;
        quociente_d = 8'd0;
        erro_d      = 1'b0;
        div0_d      = (B == 8'd0);
        contador_d  = 3'd7;
        state_d     = CALC;
      end
      CALC: if (div0_q) begin
        // Division by zero short-circuits to the result 8 zero-subtractions would give.
        q_d     = 8'hFF;
        r_d     = dividendo_q;
        erro_d  = 1'b1;
        state_d = FIM;
      end else begin
        resto_d     = resto_nx;
        quociente_d = quociente_nx;
        contador_d  = contador_q - 3'd1;
        if (contador_q == 3'd0) begin
          q_d     = quociente_nx;
          r_d     = resto_nx;
          state_d = FIM;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OCIOSO;
      dividendo_q <= 8'd0;
      divisor_q   <= 8'd0;
      resto_q     <= 8'd0;
      quociente_q <= 8'd0;
      contador_q  <= 3'd0;
      q_q         <= 8'd0;
      r_q         <= 8'd0;
      erro_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividendo_q <= dividendo_d;
      divisor_q   <= divisor_d;
      resto_q     <= resto_d;
      quociente_q <= quociente_d;
      contador_q  <= contador_d;
      q_q         <= q_d;
      r_q         <= r_d;
      erro_q      <= erro_d;
      div0_q      <= div0_d;
    end
  end
  assign Q         = q_q;
  assign R         = r_q;
  assign erro_div0 = erro_q;
  assign busy      = (state_q == CALC) || (state_q == FIM);
  assign done      = (state_q == FIM);
endmodule

// File: tb/tb_controledivisao8x8.sv
// tb_controledivisao8x8: directed and randomized checks of the sequential divider against arithmetic division.
module tb_controledivisao8x8;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] A, B, Q, R;
  logic       busy, done, erro_div0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pq = 8'd0;
  logic [7:0] pr = 8'd0;

  controledivisao8x8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .erro_div0(erro_div0)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    return {1'b0, 8'(a / b), 8'(a % b)};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation from idle; poke>0 raises start with junk operands before edge k+poke.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int poke);
    logic [16:0] e;
    int lat;
    e = ref_div(a, b);
    lat = (b == 8'd0) ? 1 : 8;
    A = a; B = b; start = 1'b1;
    step;
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    check("acc_busy", busy, 1);
    check("acc_done", done, 0);
    for (int i = 1; i < lat; i++) begin
      if (i == poke) begin start = 1'b1; A = 8'($urandom); B = 8'($urandom); end
      step;
      start = 1'b0;
      check("calc_done", done, 0);
      check("calc_busy", busy, 1);
      check("calc_q_hold", Q, pq);
      check("calc_r_hold", R, pr);
    end
    step;
    check("fim_done", done, 1);
    check("fim_busy", busy, 1);
    check("fim_q", Q, e[15:8]);
    check("fim_r", R, e[7:0]);
    check("fim_erro", erro_div0, e[16]);
    pq = e[15:8]; pr = e[7:0];
    step;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_q", Q, pq);
    check("idle_r", R, pr);
  endtask

  initial begin
    logic [16:0] e;
    logic [7:0]  ca, cb;
    int          since, waited;
    rst_n = 1'b0; start = 1'b1; A = 8'd200; B = 8'd7;
    step; step;
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro_div0, 0);
    start = 1'b0; rst_n = 1'b1;
    step;
    check("rst_idle_busy", busy, 0);

    run_div(8'd200, 8'd7, 0);
    run_div(8'd255, 8'd1, 0);
    run_div(8'd5, 8'd9, 0);
    run_div(8'd255, 8'd129, 0);
    run_div(8'd77, 8'd0, 0);
    run_div(8'd10, 8'd3, 0);
    run_div(8'd100, 8'd10, 3);
    run_div(8'd0, 8'd255, 0);
    run_div(8'd255, 8'd255, 0);

    // Abort an operation with reset at edge k+4.
    A = 8'd200; B = 8'd7; start = 1'b1;
    step;
    start = 1'b0;
    step; step; step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_erro", erro_div0, 0);
    pq = 8'd0; pr = 8'd0;
    waited = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (done) waited++;
    end
    check("abort_no_done", waited, 0);
    run_div(8'd50, 8'd8, 0);

    // Back-to-back random operations with start held high.
    ca = 8'($urandom); cb = 8'($urandom);
    A = ca; B = cb; start = 1'b1; since = 0;
    for (int n = 0; n < 300; n++) begin
      waited = 0;
      do begin
        step;
        since++;
        waited++;
      end while (!done && waited < 20);
      check("tp_done_seen", done, 1);
      if (n > 0) check("tp_interval", since, (cb == 8'd0) ? 3 : 10);
      e = ref_div(ca, cb);
      check("tp_q", Q, e[15:8]);
      check("tp_r", R, e[7:0]);
      check("tp_erro", erro_div0, e[16]);
      since = 0;
      ca = 8'($urandom);
      cb = (n % 41 == 7) ? 8'd0 : 8'($urandom);
      A = ca; B = cb;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) step;
    check("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
